// File: rtl/butterfly_pkg.sv
// Shared types and arithmetic helpers for the FFT butterfly pipeline.
// Helpers work on a 64-bit signed carrier wide enough for every datapath width.
package butterfly_pkg;

    localparam int TW_ONE = 2 ** 14;
    localparam int WIDE_W = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef struct packed {
        wide_t value;
        logic  sat;
    } sat_t;

    function automatic wide_t round_shift(input wide_t v, input int sh, input logic rnd);
        wide_t bias;
        bias = '0;
        if (rnd && sh > 0)
            bias = wide_t'(1) <<< (sh - 1);
        return (v + bias) >>> sh;
    endfunction

    function automatic sat_t sat_to_width(input wide_t v, input int n);
        wide_t hi;
        wide_t lo;
        sat_t  r;
        hi = (wide_t'(1) <<< (n - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        r.value = v;
        r.sat = 1'b0;
        if (v > hi) begin
            r.value = hi;
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.value = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/butterfly_pipe_complex_mult.sv
// Twiddle multiply and fixed-point product shift, two register stages deep.
// The operand A path and per-sample controls ride alongside the product.
module complex_mult
    import butterfly_pkg::*;
#(
    parameter int DATA_WIDTH        = 24,
    parameter int TWIDDLE_WIDTH     = 16,
    parameter int TWIDDLE_FRAC_BITS = 14,
    parameter int ROUND             = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         en,
    input  logic                                         in_valid,
    input  logic signed [DATA_WIDTH-1:0]                 in1_re,
    input  logic signed [DATA_WIDTH-1:0]                 in1_im,
    input  logic signed [DATA_WIDTH-1:0]                 in2_re,
    input  logic signed [DATA_WIDTH-1:0]                 in2_im,
    input  logic signed [TWIDDLE_WIDTH-1:0]              tw_re,
    input  logic signed [TWIDDLE_WIDTH-1:0]              tw_im,
    input  logic                                         inverse,
    input  logic                                         scale_en,
    output logic                                         out_valid,
    output logic                                         out_scale,
    output logic signed [DATA_WIDTH-1:0]                 out_in1_re,
    output logic signed [DATA_WIDTH-1:0]                 out_in1_im,
    output logic signed [DATA_WIDTH+TWIDDLE_WIDTH+1:0]   prod_re,
    output logic signed [DATA_WIDTH+TWIDDLE_WIDTH+1:0]   prod_im
);

    localparam int PW = DATA_WIDTH + TWIDDLE_WIDTH + 1;
    localparam int SW = PW + 1;
    localparam logic signed [TWIDDLE_WIDTH-1:0] TW_MIN = {1'b1, {(TWIDDLE_WIDTH-1){1'b0}}};
    localparam logic signed [TWIDDLE_WIDTH-1:0] TW_MAX = {1'b0, {(TWIDDLE_WIDTH-1){1'b1}}};

    logic signed [TWIDDLE_WIDTH-1:0] wi;
    logic signed [PW-1:0]            pr;
    logic signed [PW-1:0]            pi;
    logic signed [PW-1:0]            pr_q;
    logic signed [PW-1:0]            pi_q;
    logic signed [DATA_WIDTH-1:0]    a_re_q;
    logic signed [DATA_WIDTH-1:0]    a_im_q;
    logic                            sc_q;
    logic                            v_q;

    // Conjugate twiddle; the most negative code cannot be negated exactly.
    always_comb begin
        wi = tw_im;
        if (inverse)
            wi = (tw_im == TW_MIN) ? TW_MAX : -tw_im;
        pr = PW'(in2_re) * PW'(tw_re) - PW'(in2_im) * PW'(wi);
        pi = PW'(in2_re) * PW'(wi) + PW'(in2_im) * PW'(tw_re);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= 1'b0;
            sc_q       <= 1'b0;
            a_re_q     <= '0;
            a_im_q     <= '0;
            pr_q       <= '0;
            pi_q       <= '0;
            out_valid  <= 1'b0;
            out_scale  <= 1'b0;
            out_in1_re <= '0;
            out_in1_im <= '0;
            prod_re    <= '0;
            prod_im    <= '0;
        end else if (en) begin
            v_q        <= in_valid;
            sc_q       <= scale_en;
            a_re_q     <= in1_re;
            a_im_q     <= in1_im;
            pr_q       <= pr;
            pi_q       <= pi;
            out_valid  <= v_q;
            out_scale  <= sc_q;
            out_in1_re <= a_re_q;
            out_in1_im <= a_im_q;
            prod_re    <= SW'(round_shift(wide_t'(pr_q), TWIDDLE_FRAC_BITS, ROUND != 0));
            prod_im    <= SW'(round_shift(wide_t'(pi_q), TWIDDLE_FRAC_BITS, ROUND != 0));
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly with valid/ready flow control, inverse mode,
// optional halving and saturating outputs with overflow reporting.
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int DATA_WIDTH        = 24,
    parameter int DATA_FRAC_BITS    = 16,
    parameter int TWIDDLE_WIDTH     = 16,
    parameter int TWIDDLE_FRAC_BITS = 14,
    parameter int ROUND             = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DATA_WIDTH-1:0]    input_1_re,
    input  logic signed [DATA_WIDTH-1:0]    input_1_im,
    input  logic signed [DATA_WIDTH-1:0]    input_2_re,
    input  logic signed [DATA_WIDTH-1:0]    input_2_im,
    input  logic signed [TWIDDLE_WIDTH-1:0] twiddle_re,
    input  logic signed [TWIDDLE_WIDTH-1:0] twiddle_im,
    input  logic                            inverse,
    input  logic                            scale_en,
    output logic signed [DATA_WIDTH-1:0]    output_1_re,
    output logic signed [DATA_WIDTH-1:0]    output_1_im,
    output logic signed [DATA_WIDTH-1:0]    output_2_re,
    output logic signed [DATA_WIDTH-1:0]    output_2_im,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            overflow,
    output logic                            overflow_sticky,
    input  logic                            clear_overflow
);

    localparam int SW = DATA_WIDTH + TWIDDLE_WIDTH + 2;

    if (DATA_FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
        $error("DATA_FRAC_BITS must be below DATA_WIDTH");
    end

    logic                         en;
    logic                         v2;
    logic                         sc2;
    logic signed [DATA_WIDTH-1:0] a2_re;
    logic signed [DATA_WIDTH-1:0] a2_im;
    logic signed [SW-1:0]         p2_re;
    logic signed [SW-1:0]         p2_im;
    sat_t                         r1_re;
    sat_t                         r1_im;
    sat_t                         r2_re;
    sat_t                         r2_im;
    logic                         ovf;

    assign en       = out_ready || !out_valid;
    assign in_ready = en && !rst;

    complex_mult #(
        .DATA_WIDTH        (DATA_WIDTH),
        .TWIDDLE_WIDTH     (TWIDDLE_WIDTH),
        .TWIDDLE_FRAC_BITS (TWIDDLE_FRAC_BITS),
        .ROUND             (ROUND)
    ) u_cmul (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid && in_ready),
        .in1_re     (input_1_re),
        .in1_im     (input_1_im),
        .in2_re     (input_2_re),
        .in2_im     (input_2_im),
        .tw_re      (twiddle_re),
        .tw_im      (twiddle_im),
        .inverse    (inverse),
        .scale_en   (scale_en),
        .out_valid  (v2),
        .out_scale  (sc2),
        .out_in1_re (a2_re),
        .out_in1_im (a2_im),
        .prod_re    (p2_re),
        .prod_im    (p2_im)
    );

    function automatic sat_t finish(input wide_t s, input logic sc);
        wide_t t;
        t = sc ? round_shift(s, 1, ROUND != 0) : s;
        return sat_to_width(t, DATA_WIDTH);
    endfunction

    always_comb begin
        r1_re = finish(wide_t'(a2_re) + wide_t'(p2_re), sc2);
        r1_im = finish(wide_t'(a2_im) + wide_t'(p2_im), sc2);
        r2_re = finish(wide_t'(a2_re) - wide_t'(p2_re), sc2);
        r2_im = finish(wide_t'(a2_im) - wide_t'(p2_im), sc2);
        ovf   = r1_re.sat | r1_im.sat | r2_re.sat | r2_im.sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            overflow        <= 1'b0;
            overflow_sticky <= 1'b0;
            output_1_re     <= '0;
            output_1_im     <= '0;
            output_2_re     <= '0;
            output_2_im     <= '0;
        end else begin
            if (en) begin
                out_valid   <= v2;
                overflow    <= v2 && ovf;
                output_1_re <= DATA_WIDTH'(r1_re.value);
                output_1_im <= DATA_WIDTH'(r1_im.value);
                output_2_re <= DATA_WIDTH'(r2_re.value);
                output_2_im <= DATA_WIDTH'(r2_im.value);
            end
            // A saturated result leaving the block beats a same-cycle clear.
            if (out_valid && out_ready && overflow)
                overflow_sticky <= 1'b1;
            else if (clear_overflow)
                overflow_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed and random checks of butterfly_pipe against an arithmetic model.
// Results are matched in order through an expected-value queue.
module tb_butterfly_pipe;

    localparam int DW = 24;
    localparam int TW = 16;
    localparam int TF = 14;
    localparam int R  = 1;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic inverse, scale_en, overflow, overflow_sticky, clear_overflow;
    logic signed [DW-1:0] i1r, i1i, i2r, i2i;
    logic signed [DW-1:0] o1r, o1i, o2r, o2i;
    logic signed [TW-1:0] twr, twi;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    typedef struct {
        longint r1;
        longint i1;
        longint r2;
        longint i2;
        bit     ovf;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    butterfly_pipe #(
        .DATA_WIDTH        (DW),
        .DATA_FRAC_BITS    (16),
        .TWIDDLE_WIDTH     (TW),
        .TWIDDLE_FRAC_BITS (TF),
        .ROUND             (R)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .input_1_re      (i1r),
        .input_1_im      (i1i),
        .input_2_re      (i2r),
        .input_2_im      (i2i),
        .twiddle_re      (twr),
        .twiddle_im      (twi),
        .inverse         (inverse),
        .scale_en        (scale_en),
        .output_1_re     (o1r),
        .output_1_im     (o1i),
        .output_2_re     (o2r),
        .output_2_im     (o2i),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .overflow        (overflow),
        .overflow_sticky (overflow_sticky),
        .clear_overflow  (clear_overflow)
    );

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint s, inout bit o);
        if (s > 8388607) begin
            o = 1'b1;
            return 8388607;
        end
        if (s < -8388608) begin
            o = 1'b1;
            return -8388608;
        end
        return s;
    endfunction

    // Butterfly result from the current input values.
    function automatic exp_t model();
        exp_t   e;
        longint wi, pr, pi;
        longint s[4];
        wi = longint'(twi);
        if (inverse)
            wi = (wi == -32768) ? 32767 : -wi;
        pr = longint'(i2r) * longint'(twr) - longint'(i2i) * wi;
        pi = longint'(i2r) * wi + longint'(i2i) * longint'(twr);
        pr = (pr + (R ? 8192 : 0)) >>> TF;
        pi = (pi + (R ? 8192 : 0)) >>> TF;
        s[0] = longint'(i1r) + pr;
        s[1] = longint'(i1i) + pi;
        s[2] = longint'(i1r) - pr;
        s[3] = longint'(i1i) - pi;
        e.ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (scale_en)
                s[k] = (s[k] + R) >>> 1;
            s[k] = clamp(s[k], e.ovf);
        end
        e.r1 = s[0];
        e.i1 = s[1];
        e.r2 = s[2];
        e.i2 = s[3];
        return e;
    endfunction

    // One clock: check outputs and record accepts at the falling edge.
    task automatic cyc();
        @(negedge clk);
        if (out_valid && !out_ready)
            chk("stall_in_ready", in_ready, 0);
        if (out_valid) begin
            chk("sb_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                chk("out1_re", o1r, q[0].r1);
                chk("out1_im", o1i, q[0].i1);
                chk("out2_re", o2r, q[0].r2);
                chk("out2_im", o2i, q[0].i2);
                chk("overflow", overflow, q[0].ovf);
                if (out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
        if (in_valid && in_ready)
            q.push_back(model());
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input longint a_r, input longint a_i, input longint b_r,
                          input longint b_i, input longint w_r, input longint w_i,
                          input bit inv, input bit sc);
        i1r = DW'(a_r);
        i1i = DW'(a_i);
        i2r = DW'(b_r);
        i2i = DW'(b_i);
        twr = TW'(w_r);
        twi = TW'(w_i);
        inverse  = inv;
        scale_en = sc;
    endtask

    task automatic set_rand();
        i1r = DW'($urandom);
        i1i = DW'($urandom);
        i2r = DW'($urandom);
        i2i = DW'($urandom);
        twr = TW'($urandom);
        twi = ($urandom_range(0, 3) == 0) ? -16'sd32768 : TW'($urandom);
        inverse  = 1'($urandom);
        scale_en = 1'($urandom);
    endtask

    // Single sample through an empty pipe with latency and value checks.
    task automatic one(input string tag, input longint e1r, input longint e1i,
                       input longint e2r, input longint e2i, input bit eovf,
                       input bit esticky);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        cyc();
        chk({tag, "_lat2"}, out_valid, 0);
        cyc();
        chk({tag, "_lat3"}, out_valid, 1);
        chk({tag, "_o1r"}, o1r, e1r);
        chk({tag, "_o1i"}, o1i, e1i);
        chk({tag, "_o2r"}, o2r, e2r);
        chk({tag, "_o2i"}, o2i, e2i);
        chk({tag, "_ovf"}, overflow, eovf);
        cyc();
        chk({tag, "_sticky"}, overflow_sticky, esticky);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && q.size() > 0; i++)
            cyc();
        chk({tag, "_drained"}, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        int p0;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clear_overflow = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sticky", overflow_sticky, 0);
        chk("rst_o1r", o1r, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        set_in(65536, 0, 65536, 0, 16384, 0, 0, 0);
        one("unity", 131072, 0, 0, 0, 0, 0);

        set_in(0, 0, 65536, 0, 0, -16384, 1, 0);
        one("inv", 0, 65536, 0, -65536, 0, 0);
        set_in(0, 0, 65536, 0, 0, -16384, 0, 0);
        one("fwd", 0, -65536, 0, 65536, 0, 0);

        set_in(8388607, 0, 8388607, 0, 16384, 0, 0, 0);
        one("sat", 8388607, 0, 0, 0, 1, 1);
        set_in(8388607, 0, 8388607, 0, 16384, 0, 0, 1);
        one("scaled", 8388607, 0, 0, 0, 0, 1);

        set_in(0, 0, 3, 0, 8192, 0, 0, 0);
        one("round", 2, 0, -2, 0, 0, 1);

        // Back-to-back random stream with a four-cycle downstream stall.
        p0 = pops;
        n = 0;
        acc = 0;
        while (acc < 8 && n < 40) begin
            if (in_valid == 1'b0 || in_ready)
                set_rand();
            in_valid = 1'b1;
            out_ready = !(n >= 5 && n < 9);
            if (in_ready)
                acc++;
            cyc();
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_accepted", acc, 8);
        drain("stream");
        chk("stream_results", pops - p0, 8);

        // Asynchronous reset with samples in flight.
        for (int i = 0; i < 3; i++) begin
            set_rand();
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_sticky", overflow_sticky, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_o1r", o1r, 0);
        chk("arst_o2i", o2i, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_sticky", overflow_sticky, 0);
        chk("arst_in_ready", in_ready, 0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("post_rst_idle", out_valid, 0);
        end

        // Clear held high across a saturating transfer: set wins.
        clear_overflow = 1'b1;
        set_in(8388607, 0, 8388607, 0, 16384, 0, 0, 0);
        one("clr_vs_set", 8388607, 0, 0, 0, 1, 1);
        cyc();
        chk("clr_alone", overflow_sticky, 0);
        clear_overflow = 1'b0;

        drain("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
